mul_err_sweep_ctrl: RTL



---
 rtl/mul_err_sweep_ctrl_if.sv | 21 ++
 rtl/mul_err_sweep_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mul_err_sweep_ctrl_if.sv
// Operand/product bus between the error-sweep sequencer
// and the approximate multiplier under test.
interface mul_err_sweep_ctrl_if #(
    parameter int W = 8
);
    logic [W-1:0]   mul_a;
    logic [W-1:0]   mul_b;
    logic [2*W-1:0] mul_p;

    modport master (
        output mul_a,
        output mul_b,
        input  mul_p
    );

    modport slave (
        input  mul_a,
        input  mul_b,
        output mul_p
    );
endinterface

// File: rtl/mul_err_sweep_ctrl.sv
// Exhaustive error-characterisation sequencer for an
// approximate WxW multiplier: sweeps all operand pairs.
module mul_err_sweep_ctrl #(
    parameter int W      = 8,
    parameter int N_PIPE = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    mul_err_sweep_ctrl_if.master  mul,
    output logic                  busy,
    output logic                  done,
    output logic                  res_valid,
    output logic [4*W+1:0]        sum_err,
    output logic [6*W-1:0]        sum_sq,
    output logic [2*W-1:0]        max_abs,
    output logic [2*W:0]          mism_cnt
);

    localparam int DW = $clog2(N_PIPE + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [2*W-1:0] idx;
    logic [DW-1:0]  dcnt;

    logic           v1;
    logic [2*W-1:0] p1;
    logic [2*W-1:0] ex1;

    logic [2*W:0]   e;
    logic [2*W-1:0] e_abs;
    logic [4*W-1:0] e_sq;
    logic           go;

    assign go        = (state == IDLE) && start && !abort;
    assign mul.mul_a = idx[2*W-1:W];
    assign mul.mul_b = idx[W-1:0];
    assign busy      = (state == RUN) || (state == DRAIN);
    assign done      = (state == DONE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; abort overrides everything
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (go) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (&idx) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (dcnt == DW'(N_PIPE - 1)) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Operand index and drain cycle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx  <= '0;
            dcnt <= '0;
        end else begin
            if (abort || go) begin
                idx <= '0;
            end else if (state == RUN) begin
                idx <= idx + 1'b1;
            end
            if (state == DRAIN && !abort) begin
                dcnt <= dcnt + 1'b1;
            end else begin
                dcnt <= '0;
            end
        end
    end

    // Stage 1: capture approximate and exact products
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1  <= 1'b0;
            p1  <= '0;
            ex1 <= '0;
        end else begin
            v1  <= (state == RUN) && !abort;
            p1  <= mul.mul_p;
            ex1 <= (2*W)'(mul.mul_a) * (2*W)'(mul.mul_b);
        end
    end

    // Error terms for stage 2
    always_comb begin
        e     = {1'b0, p1} - {1'b0, ex1};
        e_abs = (p1 >= ex1) ? (p1 - ex1) : (ex1 - p1);
        e_sq  = (4*W)'(e_abs) * (4*W)'(e_abs);
    end

    // Stage 2: accumulate; partial sums survive an abort
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_err  <= '0;
            sum_sq   <= '0;
            max_abs  <= '0;
            mism_cnt <= '0;
        end else if (go) begin
            sum_err  <= '0;
            sum_sq   <= '0;
            max_abs  <= '0;
            mism_cnt <= '0;
        end else if (v1) begin
            sum_err  <= sum_err + {{(2*W+1){e[2*W]}}, e};
            sum_sq   <= sum_sq + {{(2*W){1'b0}}, e_sq};
            mism_cnt <= mism_cnt + {{(2*W){1'b0}}, (e != '0)};
            if (e_abs > max_abs) begin
                max_abs <= e_abs;
            end
        end
    end

    // Result-valid flag rises together with done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
        end else if (abort || go) begin
            res_valid <= 1'b0;
        end else if (state_nx == DONE) begin
            res_valid <= 1'b1;
        end
    end

endmodule
